// File: rtl/vga_sync_decoder.sv
// Receive-side VGA sync decoder: recovers pixel coordinates from hSync/vSync,
// checks line/frame timing, and accumulates a per-frame RGB checksum.
module vga_sync_decoder #(
    parameter int unsigned H_VISIBLE       = 640,
    parameter int unsigned H_FRONT         = 16,
    parameter int unsigned H_SYNC          = 96,
    parameter int unsigned H_BACK          = 48,
    parameter int unsigned V_VISIBLE       = 480,
    parameter int unsigned V_FRONT         = 10,
    parameter int unsigned V_SYNC          = 2,
    parameter int unsigned V_BACK          = 33,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hSync,
    input  logic        vSync,
    input  logic [11:0] rgb,
    input  logic        err_clr,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        locked,
    output logic        frame_done,
    output logic [31:0] frame_sum,
    output logic [15:0] frame_count,
    output logic [3:0]  err_flags
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HCW     = $clog2(H_TOTAL + 1);
    localparam int unsigned VCW     = $clog2(V_TOTAL + 1);

    localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_SYNC_C = HCW'(H_SYNC);
    localparam logic [HCW-1:0] H_X0     = HCW'(H_SYNC + H_BACK);
    localparam logic [HCW-1:0] H_X1     = HCW'(H_SYNC + H_BACK + H_VISIBLE - 1);
    localparam logic [VCW-1:0] V_TOT_C  = VCW'(V_TOTAL);
    localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_SYNC_C = VCW'(V_SYNC);
    localparam logic [VCW-1:0] V_Y0     = VCW'(V_SYNC + V_BACK);
    localparam logic [VCW-1:0] V_Y1     = VCW'(V_SYNC + V_BACK + V_VISIBLE - 1);

    typedef enum logic [1:0] {StSearch, StCheck, StLocked} state_e;

    state_e          state_q, state_d;
    logic            hs_prev_q, h_seen_q, h_over_q, h_over_d;
    logic            vs_prev_q, v_seen_q;
    logic [HCW-1:0]  hc_q, hc_d, hc_inc;
    logic [VCW-1:0]  vc_q, vc_d, vs_cnt_q, vs_cnt_d;
    logic [31:0]     sum_q, sum_d;

    logic            pix_valid_q, frame_done_q, locked_q;
    logic [9:0]      pix_x_q, pix_y_q;
    logic [11:0]     pix_rgb_q;
    logic [31:0]     frame_sum_q;
    logic [15:0]     frame_count_q;
    logic [3:0]      err_flags_q;

    logic            hs_act, vs_act, hs_start, hs_end, frame_start, vs_end;
    logic            visible, emit, last_px;
    logic [3:0]      err;

    assign hs_act      = (hSync == !SYNC_ACTIVE_LOW);
    assign vs_act      = (vSync == !SYNC_ACTIVE_LOW);
    assign hs_start    = hs_act && !hs_prev_q;
    assign hs_end      = !hs_act && hs_prev_q;
    assign frame_start = hs_start && vs_act && !vs_prev_q;
    assign vs_end      = hs_start && !vs_act && vs_prev_q;
    assign hc_inc      = hc_q + 1'b1;

    // Counters and timing checks; everything is qualified by the pixel tick.
    always_comb begin
        err = '0;
        if (pix_en) begin
            if (h_seen_q && hs_start && hc_q != H_LAST) err[0] = 1'b1;
            if (h_seen_q && !hs_start && hc_q == H_LAST && !h_over_q) err[0] = 1'b1;
            if (h_seen_q && hs_end && hc_inc != H_SYNC_C) err[1] = 1'b1;
            if (frame_start && state_q != StSearch && vc_q != V_LAST) err[2] = 1'b1;
            if (v_seen_q && hs_start && !frame_start && vc_q == V_LAST) err[2] = 1'b1;
            if (v_seen_q && vs_end && vs_cnt_q != V_SYNC_C) err[3] = 1'b1;
        end

        // hc saturates at the last count so a missing sync is flagged only once
        h_over_d = !hs_start && (hc_q == H_LAST);
        if (hs_start) begin
            hc_d = '0;
        end else if (hc_q == H_LAST) begin
            hc_d = hc_q;
        end else begin
            hc_d = hc_inc;
        end

        vc_d     = vc_q;
        vs_cnt_d = vs_cnt_q;
        if (frame_start) begin
            vc_d     = '0;
            vs_cnt_d = VCW'(1);
        end else if (hs_start) begin
            if (vc_q != V_TOT_C) vc_d = vc_q + 1'b1;
            if (vs_act && vs_cnt_q != V_TOT_C) vs_cnt_d = vs_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (pix_en) begin
            unique case (state_q)
                StSearch: if (frame_start && err == '0) state_d = StCheck;
                StCheck: begin
                    if (err != '0)       state_d = StSearch;
                    else if (frame_start) state_d = StLocked;
                end
                StLocked: if (err != '0) state_d = StSearch;
                default: state_d = StSearch;
            endcase
        end
    end

    always_comb begin
        visible = (hc_d >= H_X0) && (hc_d <= H_X1) && (vc_d >= V_Y0) && (vc_d <= V_Y1);
        emit    = pix_en && visible && (state_d == StLocked);
        last_px = (hc_d == H_X1) && (vc_d == V_Y1);
        sum_d   = sum_q;
        if (pix_en && frame_start) begin
            sum_d = '0;
        end else if (emit) begin
            sum_d = sum_q + 32'(rgb);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StSearch;
            hs_prev_q     <= 1'b0;
            h_seen_q      <= 1'b0;
            h_over_q      <= 1'b0;
            vs_prev_q     <= 1'b0;
            v_seen_q      <= 1'b0;
            hc_q          <= '0;
            vc_q          <= '0;
            vs_cnt_q      <= '0;
            sum_q         <= '0;
            pix_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            locked_q      <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_rgb_q     <= '0;
            frame_sum_q   <= '0;
            frame_count_q <= '0;
            err_flags_q   <= '0;
        end else begin
            state_q <= state_d;
            if (pix_en) begin
                hs_prev_q <= hs_act;
                h_over_q  <= h_over_d;
                hc_q      <= hc_d;
                vc_q      <= vc_d;
                vs_cnt_q  <= vs_cnt_d;
                sum_q     <= sum_d;
                if (hs_start) begin
                    h_seen_q  <= 1'b1;
                    vs_prev_q <= vs_act;
                end
                if (frame_start) v_seen_q <= 1'b1;
            end

            pix_valid_q  <= emit;
            frame_done_q <= emit && last_px;
            locked_q     <= (state_d == StLocked);
            if (emit) begin
                pix_x_q   <= 10'(hc_d - H_X0);
                pix_y_q   <= 10'(vc_d - V_Y0);
                pix_rgb_q <= rgb;
            end
            if (emit && last_px) begin
                frame_sum_q   <= sum_d;
                frame_count_q <= frame_count_q + 16'd1;
            end

            // A clear on the same edge as a new error drops that error
            if (err_clr) err_flags_q <= '0;
            else         err_flags_q <= err_flags_q | err;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign locked      = locked_q;
    assign frame_done  = frame_done_q;
    assign frame_sum   = frame_sum_q;
    assign frame_count = frame_count_q;
    assign err_flags   = err_flags_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a miniature 14x7 raster.
module tb_vga_sync_decoder;

    localparam int HV = 8, HF = 2, HS = 2, HB = 2;
    localparam int VV = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HV + HF + HS + HB;

    logic        clk = 1'b0;
    logic        reset, pix_en, hSync, vSync, err_clr;
    logic [11:0] rgb;
    logic        pix_valid, locked, frame_done;
    logic [9:0]  pix_x, pix_y;
    logic [11:0] pix_rgb;
    logic [31:0] frame_sum;
    logic [15:0] frame_count;
    logic [3:0]  err_flags;

    vga_sync_decoder #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hSync(hSync), .vSync(vSync),
        .rgb(rgb), .err_clr(err_clr), .pix_valid(pix_valid), .pix_x(pix_x),
        .pix_y(pix_y), .pix_rgb(pix_rgb), .locked(locked), .frame_done(frame_done),
        .frame_sum(frame_sum), .frame_count(frame_count), .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [9:0] x; logic [9:0] y; logic [11:0] c;} pix_t;
    typedef struct packed {logic [31:0] s; logic [15:0] n;} fd_t;

    pix_t        pix_q[$];
    fd_t         fd_q[$];
    int          checks = 0;
    int          errors = 0;
    int          clean_starts = 0;
    logic [31:0] run_sum;
    logic [15:0] exp_count = 0;
    bit          use_fixed = 1'b0;
    logic [11:0] fixed_rgb = 12'h000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input bit hs, input bit vs, input logic [11:0] c);
        @(negedge clk);
        pix_en = 1'b1; hSync = ~hs; vSync = ~vs; rgb = c;
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {pix_valid, frame_done, locked, err_flags, frame_count, pix_x, pix_y},
              64'd0);
        check({name, "_sum"}, frame_sum, 64'd0);
        check({name, "_rgb"}, pix_rgb, 64'd0);
    endtask

    // One frame of nlines lines. A line equal to bad_line carries bad_hs sync ticks instead
    // of HS. chk_line/chk_tick marks the tick where an error is expected (frame is faulty);
    // rst_line/rst_tick asserts reset on that tick and abandons the frame.
    task automatic send_frame(input int nlines, input int vs_lines, input int bad_line,
                              input int bad_hs, input int chk_line, input int chk_tick,
                              input logic [3:0] chk_flags, input int rst_line,
                              input int rst_tick);
        bit lk;
        clean_starts++;
        lk = (clean_starts >= 2) && (chk_line < 0);
        run_sum = 0;
        for (int l = 0; l < nlines; l++) begin
            for (int t = 0; t < HT; t++) begin
                bit          hs, vs;
                logic [11:0] c;
                int          x, y;
                hs = (l == bad_line) ? (t < bad_hs) : (t < HS);
                vs = (l < vs_lines);
                c  = use_fixed ? fixed_rgb : 12'($urandom);
                if (l == rst_line && t == rst_tick) begin
                    @(negedge clk);
                    reset = 1'b0; pix_en = 1'b1; hSync = ~hs; vSync = ~vs; rgb = c;
                    @(negedge clk);
                    pix_en = 1'b0;
                    check_all_zero("midframe_reset");
                    reset = 1'b1;
                    return;
                end
                x = t - (HS + HB);
                y = l - (VS + VB);
                if (lk && x >= 0 && x < HV && y >= 0 && y < VV) begin
                    pix_q.push_back(pix_t'{10'(x), 10'(y), c});
                    run_sum += 32'(c);
                    if (x == HV - 1 && y == VV - 1) begin
                        exp_count++;
                        fd_q.push_back(fd_t'{run_sum, exp_count});
                    end
                end
                tick(hs, vs, c);
                if (l == chk_line && t == chk_tick) begin
                    check("err_flags_at_fault", err_flags, chk_flags);
                    check("locked_drop", locked, 0);
                end
            end
        end
    endtask

    task automatic clean_frame();
        send_frame(VV + VF + VS + VB, VS, -1, 0, -1, 0, 4'b0, -1, 0);
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr", err_flags, 0);
    endtask

    initial begin
        reset = 1'b0; pix_en = 1'b0; hSync = 1'b1; vSync = 1'b1; rgb = '0; err_clr = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (pix_valid) begin
                    if (pix_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL pix_unexpected: got x=%0d y=%0d expected none", pix_x, pix_y);
                    end else begin
                        check("pix", {pix_x, pix_y, pix_rgb}, pix_q.pop_front());
                    end
                end
                if (frame_done) begin
                    if (fd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL frame_done_unexpected: got sum=%0d expected none", frame_sum);
                    end else begin
                        check("frame_done", {frame_sum, frame_count}, fd_q.pop_front());
                    end
                end
            end
        join_none

        // Reset with random inputs
        repeat (4) begin
            @(negedge clk);
            pix_en = 1'($urandom); hSync = 1'($urandom); vSync = 1'($urandom);
            rgb = 12'($urandom); err_clr = 1'($urandom);
        end
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1; pix_en = 1'b0; hSync = 1'b1; vSync = 1'b1; err_clr = 1'b0;

        // Three clean frames with a constant colour
        use_fixed = 1'b1; fixed_rgb = 12'h00F;
        clean_frame();
        check("locked_after_first_start", locked, 0);
        clean_frame();
        check("count_frame2", frame_count, 1);
        clean_frame();
        check("sum_frame3", frame_sum, 480);
        check("count_frame3", frame_count, 2);
        check("flags_clean", err_flags, 0);
        check("locked_clean", locked, 1);
        use_fixed = 1'b0;

        // hSync held 3 ticks on line 1
        send_frame(7, VS, 1, 3, 1, 3, 4'b0010, -1, 0);
        clean_starts = 0;
        clean_frame();
        clean_frame();
        check("relock_after_hwidth", locked, 1);
        pulse_err_clr();

        // hSync omitted at the start of line 1
        send_frame(7, VS, 1, 0, 1, 0, 4'b0001, -1, 0);
        clean_starts = 0;
        clean_frame();
        clean_frame();
        check("relock_after_hperiod", locked, 1);
        pulse_err_clr();

        // vSync two lines wide, then an 8-line frame
        send_frame(7, 2, -1, 0, 2, 0, 4'b1000, -1, 0);
        clean_starts = 0;
        send_frame(8, VS, -1, 0, 7, 0, 4'b1100, -1, 0);
        clean_starts = 0;

        // Lock, then reset mid-frame at pixel (3,2) and relock
        clean_frame();
        clean_frame();
        use_fixed = 1'b1; fixed_rgb = 12'hFFF;
        send_frame(7, VS, -1, 0, -1, 0, 4'b0, 2 + VS + VB, 3 + HS + HB);
        clean_starts = 0;
        exp_count = 0;
        clean_frame();
        clean_frame();
        check("sum_after_reset", frame_sum, 32 * 4095);
        check("count_after_reset", frame_count, 1);

        repeat (4) @(negedge clk);
        check("pix_queue_drained", pix_q.size(), 0);
        check("fd_queue_drained", fd_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
